// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer with rename launch and
// registered commit notification toward the register file.
// Optional feature: define ROB_WB_BYPASS_EN so that a writeback to the head
// entry retires it at the same edge, taking the value straight from _wb_value.
module reorder_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _flush_in,
  input  logic        _iss_valid,
  input  logic [4:0]  _iss_rd,
  output logic        _iss_ready,
  output logic [4:0]  _iss_rob_id,
  output logic        _rob_launch_ready,
  output logic [4:0]  _rob_launch_rob_id,
  output logic [4:0]  _rob_launch_register_id,
  input  logic        _wb_valid,
  input  logic [4:0]  _wb_rob_id,
  input  logic [31:0] _wb_value,
  output logic        _rob_commit_ready,
  output logic [4:0]  _rob_commit_rob_id,
  output logic [4:0]  _rob_commit_register_id,
  output logic [31:0] _rob_commit_value,
  output logic [4:0]  _rob_count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [4:0]       DEPTH_ID = 5'(DEPTH);

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [4:0]       count_r;
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] done_r;
  logic [4:0]       rd_r    [DEPTH];
  logic [31:0]      value_r [DEPTH];

  logic             commit_ready_r;
  logic [4:0]       commit_rob_id_r;
  logic [4:0]       commit_rd_r;
  logic [31:0]      commit_value_r;

  logic             active_s;
  logic             iss_fire_s;
  logic [PTR_W-1:0] wb_idx_s;
  logic             wb_in_range_s;
  logic             wb_fire_s;
  logic             bypass_s;
  logic             retire_s;
  logic [31:0]      retire_value_s;
  logic [4:0]       count_next_s;

  // Pointer increment with wrap from the last entry back to entry 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode: issue, writeback, retire and the resulting occupancy.
  always_comb begin
    active_s       = rdy_in && !_flush_in;
    _iss_ready     = active_s && (count_r < DEPTH_ID);
    _iss_rob_id    = 5'(tail_r) + 5'd1;
    iss_fire_s     = _iss_valid && _iss_ready;
    wb_idx_s       = PTR_W'(_wb_rob_id - 5'd1);
    wb_in_range_s  = (_wb_rob_id != 5'd0) && (_wb_rob_id <= DEPTH_ID);
    wb_fire_s      = active_s && _wb_valid && wb_in_range_s &&
                     busy_r[wb_idx_s] && !done_r[wb_idx_s];
`ifdef ROB_WB_BYPASS_EN
    bypass_s       = wb_fire_s && (wb_idx_s == head_r);
`else
    bypass_s       = 1'b0;
`endif
    retire_s       = active_s && busy_r[head_r] && (done_r[head_r] || bypass_s);
    retire_value_s = bypass_s ? _wb_value : value_r[head_r];
    case ({iss_fire_s, retire_s})
      2'b10:   count_next_s = count_r + 5'd1;
      2'b01:   count_next_s = count_r - 5'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Rename notification follows the accepted issue in the same cycle.
  always_comb begin
    _rob_launch_ready       = iss_fire_s && (_iss_rd != 5'd0);
    _rob_launch_rob_id      = _iss_rob_id;
    _rob_launch_register_id = _iss_rd;
  end

  // Control state: pointers, occupancy and per-entry busy/done flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 5'd0;
      busy_r  <= '0;
      done_r  <= '0;
    end else if (rdy_in) begin
      if (_flush_in) begin
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= 5'd0;
        busy_r  <= '0;
        done_r  <= '0;
      end else begin
        if (wb_fire_s) begin
          done_r[wb_idx_s] <= 1'b1;
        end
        // Retire clears after the writeback so a bypassed head ends up empty.
        if (retire_s) begin
          busy_r[head_r] <= 1'b0;
          done_r[head_r] <= 1'b0;
          head_r         <= next_ptr(head_r);
        end
        if (iss_fire_s) begin
          busy_r[tail_r] <= 1'b1;
          done_r[tail_r] <= 1'b0;
          tail_r         <= next_ptr(tail_r);
        end
        count_r <= count_next_s;
      end
    end
  end

  // Entry payload storage; validity is carried entirely by busy_r/done_r.
  always_ff @(posedge clk_in) begin
    if (iss_fire_s) begin
      rd_r[tail_r] <= _iss_rd;
    end
    if (wb_fire_s) begin
      value_r[wb_idx_s] <= _wb_value;
    end
  end

  // Commit pulse: one cycle per retire with a real destination, else idle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_ready_r  <= 1'b0;
      commit_rob_id_r <= 5'd0;
      commit_rd_r     <= 5'd0;
      commit_value_r  <= 32'd0;
    end else if (retire_s && (rd_r[head_r] != 5'd0)) begin
      commit_ready_r  <= 1'b1;
      commit_rob_id_r <= 5'(head_r) + 5'd1;
      commit_rd_r     <= rd_r[head_r];
      commit_value_r  <= retire_value_s;
    end else begin
      commit_ready_r  <= 1'b0;
    end
  end

  // The commit strobe is masked while the block is stalled.
  always_comb begin
    _rob_commit_ready       = commit_ready_r && rdy_in;
    _rob_commit_rob_id      = commit_rob_id_r;
    _rob_commit_register_id = commit_rd_r;
    _rob_commit_value       = commit_value_r;
    _rob_count              = count_r;
  end

endmodule
